// File: rtl/cache_refill_wb_bridge.sv
// cache_refill_wb_bridge
// Serves the cache controller's line-refill port. Each refill request becomes one
// Wishbone B3 incrementing read burst. The whole line is buffered and then returned
// to the cache as LINE_WORDS back-to-back ack/data beats. Bus errors restart the
// burst up to MAX_RETRY times. After that an all-zero line is returned with
// err_mem2cc on beat 0.
//
// Optional build macro: REFILL_TIMEOUT_EN. A missing wb_ack_i for TIMEOUT_CYCLES
// cycles is then handled exactly like wb_err_i.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_cc2mem, adr_cc2mem   refill request (level) and miss address from the cache
//   ack_mem2cc, dat_mem2cc   delivery beat valid and refill word to the cache
//   err_mem2cc               line-invalid pulse, coincident with delivery beat 0
//   wb_cyc_o .. wb_bte_o     Wishbone B3 master outputs (read-only, linear bursts)
//   wb_dat_i, wb_ack_i,
//   wb_err_i                 Wishbone B3 master inputs
module cache_refill_wb_bridge #(
    parameter int unsigned ADR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINE_WORDS     = 4,
    parameter int unsigned MAX_RETRY      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_cc2mem,
    input  logic [ADR_WIDTH-1:0]    adr_cc2mem,
    output logic                    ack_mem2cc,
    output logic [DATA_WIDTH-1:0]   dat_mem2cc,
    output logic                    err_mem2cc,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADR_WIDTH-1:0]    wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int unsigned BEAT_W  = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W   = BEAT_W + 2;
    localparam int unsigned BASE_W  = ADR_WIDTH - OFF_W;
    localparam int unsigned SEL_W   = DATA_WIDTH / 8;
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [2:0]        CTI_INCR  = 3'b010;
    localparam logic [2:0]        CTI_END   = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS      = 2'd1,
        DELIVER  = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    state_t              state_q, state_n;
    logic [BASE_W-1:0]   base_q, base_n;
    logic [BEAT_W-1:0]   beat_q, beat_n;
    logic [RETRY_W-1:0]  retry_q, retry_n;
    logic                gap_q, gap_n;
    logic                abandon_q, abandon_n;
    logic                cyc_n;
    logic                ack_n, err_n;
    logic [DATA_WIDTH-1:0] dat_n;
    logic [ADR_WIDTH-1:0]  adr_n;
    logic [2:0]          cti_n;
    logic                buf_we_c, buf_clr_c;
    logic                bus_err_c;

    logic [DATA_WIDTH-1:0] line_buf [LINE_WORDS];

    // Read-only bridge, linear bursts only
    assign wb_we_o  = 1'b0;
    assign wb_bte_o = 2'b00;

`ifdef REFILL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_n;
    logic             unused_ok;

    // Per-beat wait counter; idle (cleared) whenever cyc is low or a beat is acked
    always_comb begin
        tmo_n = '0;
        if (state_q == BUS && wb_cyc_o && !wb_ack_i) begin
            tmo_n = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_n;
        end
    end

    assign bus_err_c = wb_err_i || (!wb_ack_i && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)));
    assign unused_ok = &{1'b0, adr_cc2mem[OFF_W-1:0]};
`else
    logic unused_ok;

    assign bus_err_c = wb_err_i;
    assign unused_ok = &{1'b0, adr_cc2mem[OFF_W-1:0], (TIMEOUT_CYCLES != 32'd0)};
`endif

    // Line buffer: filled beat by beat from the bus, zeroed when the line is given up
    always_ff @(posedge clk) begin
        if (buf_clr_c) begin
            for (int i = 0; i < int'(LINE_WORDS); i++) begin
                line_buf[i] <= '0;
            end
        end else if (buf_we_c) begin
            line_buf[beat_q] <= wb_dat_i;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            beat_q     <= '0;
            retry_q    <= '0;
            gap_q      <= 1'b0;
            abandon_q  <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_adr_o   <= '0;
            wb_sel_o   <= '0;
            wb_cti_o   <= 3'b000;
            ack_mem2cc <= 1'b0;
            dat_mem2cc <= '0;
            err_mem2cc <= 1'b0;
        end else begin
            state_q    <= state_n;
            base_q     <= base_n;
            beat_q     <= beat_n;
            retry_q    <= retry_n;
            gap_q      <= gap_n;
            abandon_q  <= abandon_n;
            wb_cyc_o   <= cyc_n;
            wb_stb_o   <= cyc_n;
            wb_adr_o   <= adr_n;
            wb_sel_o   <= {SEL_W{cyc_n}};
            wb_cti_o   <= cti_n;
            ack_mem2cc <= ack_n;
            dat_mem2cc <= dat_n;
            err_mem2cc <= err_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state_q;
        base_n    = base_q;
        beat_n    = beat_q;
        retry_n   = retry_q;
        gap_n     = 1'b0;
        abandon_n = abandon_q;
        cyc_n     = wb_cyc_o;
        ack_n     = 1'b0;
        err_n     = 1'b0;
        dat_n     = '0;
        buf_we_c  = 1'b0;
        buf_clr_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                retry_n   = '0;
                abandon_n = 1'b0;
                if (req_cc2mem) begin
                    base_n  = adr_cc2mem[ADR_WIDTH-1:OFF_W];
                    beat_n  = '0;
                    cyc_n   = 1'b1;
                    state_n = BUS;
                end
            end

            BUS: begin
                // A released request still finishes the burst but skips delivery
                if (!req_cc2mem) begin
                    abandon_n = 1'b1;
                end
                if (gap_q) begin
                    // One idle bus cycle after an error, then refetch from beat 0
                    beat_n = '0;
                    cyc_n  = 1'b1;
                end else if (bus_err_c) begin
                    cyc_n  = 1'b0;
                    beat_n = '0;
                    if (retry_q < RETRY_W'(MAX_RETRY)) begin
                        retry_n = retry_q + RETRY_W'(1);
                        gap_n   = 1'b1;
                    end else begin
                        buf_clr_c = 1'b1;
                        if (abandon_n) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DELIVER;
                            ack_n   = 1'b1;
                            err_n   = 1'b1;
                        end
                    end
                end else if (wb_ack_i) begin
                    buf_we_c = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        cyc_n  = 1'b0;
                        beat_n = '0;
                        if (abandon_n) begin
                            state_n = IDLE;
                        end else begin
                            // Beat 0 was stored earlier, so delivery starts on this edge
                            state_n = DELIVER;
                            ack_n   = 1'b1;
                            dat_n   = line_buf[0];
                        end
                    end else begin
                        beat_n = beat_q + BEAT_W'(1);
                    end
                end
            end

            DELIVER: begin
                // beat_q is the index already on dat_mem2cc
                if (beat_q == LAST_BEAT) begin
                    beat_n  = '0;
                    state_n = WAIT_REL;
                end else begin
                    beat_n = beat_q + BEAT_W'(1);
                    ack_n  = 1'b1;
                    dat_n  = line_buf[beat_n];
                end
            end

            WAIT_REL: begin
                if (!req_cc2mem) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        adr_n = cyc_n ? {base_n, beat_n, 2'b00} : '0;
        cti_n = !cyc_n ? 3'b000 : ((beat_n == LAST_BEAT) ? CTI_END : CTI_INCR);
    end

endmodule

// File: tb/tb_cache_refill_wb_bridge.sv
// Scoreboard bench for cache_refill_wb_bridge: the stimulus pushes expected delivery
// beats and expected observations. A negedge process models the Wishbone slave
// (mem[a] = a, optional waits and injected errors) and performs all comparisons.
module tb_cache_refill_wb_bridge;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_cc2mem;
    logic [31:0] adr_cc2mem;
    logic        ack_mem2cc;
    logic [31:0] dat_mem2cc;
    logic        err_mem2cc;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    cache_refill_wb_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .req_cc2mem (req_cc2mem),
        .adr_cc2mem (adr_cc2mem),
        .ack_mem2cc (ack_mem2cc),
        .dat_mem2cc (dat_mem2cc),
        .err_mem2cc (err_mem2cc),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cti_o   (wb_cti_o),
        .wb_bte_o   (wb_bte_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } beat_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } cmp_t;

    beat_t exp_q[$];
    cmp_t  cmp_q[$];

    // Written only by the stimulus
    int          wait_mode;
    int          err_beat;
    int          err_attempts;
    int          burst_base;
    logic [31:0] cur_base;

    // Written only by the monitor/slave process
    int checks   = 0;
    int failures = 0;
    int bursts   = 0;
    int bus_acks = 0;
    int wait_sum = 0;
    int slv_beat = 0;
    int pend     = -1;
    int run_len  = 0;
    bit prev_cyc = 1'b0;

    task automatic expect_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_q.push_back('{name: name, act: act, exp: exp});
    endtask

    // Monitor + Wishbone slave model
    always @(negedge clk) begin
        cmp_t        c;
        beat_t       e;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;

        while (cmp_q.size() > 0) begin
            c = cmp_q.pop_front();
            checks++;
            if (c.act != c.exp) begin
                failures++;
                $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
            end
        end

        if (rst) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'h0;
            pend     = -1;
            prev_cyc = 1'b0;
            run_len  = 0;
        end else begin
            if (ack_mem2cc) begin
                run_len++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL deliver_unexpected: got dat=%h err=%b", dat_mem2cc, err_mem2cc);
                end else begin
                    e = exp_q.pop_front();
                    if (dat_mem2cc != e.dat || err_mem2cc != e.err) begin
                        failures++;
                        $display("FAIL deliver_beat: got dat=%h err=%b expected dat=%h err=%b",
                                 dat_mem2cc, err_mem2cc, e.dat, e.err);
                    end
                end
            end else begin
                if (run_len != 0) begin
                    checks++;
                    if (run_len != LW) begin
                        failures++;
                        $display("FAIL deliver_run_len: got %0d expected %0d", run_len, LW);
                    end
                    run_len = 0;
                end
                if (dat_mem2cc != 32'h0 || err_mem2cc) begin
                    checks++;
                    failures++;
                    $display("FAIL idle_outputs: got dat=%h err=%b expected 0", dat_mem2cc, err_mem2cc);
                end
            end

            if (wb_cyc_o && !prev_cyc) begin
                bursts++;
                slv_beat = 0;
            end
            prev_cyc = wb_cyc_o;

            if (wb_cyc_o && wb_stb_o) begin
                if (pend < 0) begin
                    pend     = (wait_mode != 0) ? int'($urandom_range(1, 10)) : 0;
                    wait_sum = wait_sum + pend;
                end
                if (pend == 0) begin
                    exp_adr = cur_base + 32'(slv_beat * 4);
                    exp_cti = (slv_beat == LW - 1) ? 3'b111 : 3'b010;
                    checks++;
                    if (wb_adr_o != exp_adr || wb_cti_o != exp_cti || wb_sel_o != 4'hF ||
                        wb_we_o != 1'b0 || wb_bte_o != 2'b00) begin
                        failures++;
                        $display("FAIL bus_beat: got adr=%h cti=%b sel=%h we=%b bte=%b expected adr=%h cti=%b sel=f we=0 bte=0",
                                 wb_adr_o, wb_cti_o, wb_sel_o, wb_we_o, wb_bte_o, exp_adr, exp_cti);
                    end
                    if (slv_beat == err_beat && (bursts - burst_base) <= err_attempts) begin
                        wb_err_i = 1'b1;
                        wb_ack_i = 1'b0;
                    end else begin
                        wb_err_i = 1'b0;
                        wb_ack_i = 1'b1;
                        wb_dat_i = wb_adr_o;
                        slv_beat++;
                        bus_acks++;
                    end
                    pend = -1;
                end else begin
                    pend--;
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                pend     = -1;
            end
        end
    end

    // One refill: queue the expected line, raise req, time the first beat,
    // hold req for 'hold' extra cycles after delivery, release, idle 'gap' cycles.
    task automatic refill(input logic [31:0] adr, input logic [31:0] line,
                          input int ebeat, input int eatt, input int exp_bursts,
                          input bit zero, input int wm, input int hold, input int gap);
        int t;
        int e;
        int wbase;
        wait_mode    = wm;
        err_beat     = ebeat;
        err_attempts = eatt;
        cur_base     = line;
        burst_base   = bursts;
        wbase        = wait_sum;
        for (int i = 0; i < LW; i++) begin
            exp_q.push_back('{dat: (zero ? 32'h0 : line + 32'(4 * i)), err: (zero && i == 0)});
        end
        @(negedge clk);
        req_cc2mem = 1'b1;
        adr_cc2mem = adr;
        e = cycle + 1;
        t = 0;
        while (!ack_mem2cc && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!ack_mem2cc) begin
            expect_eq("deliver_timeout", 64'(0), 64'(1));
        end else if (eatt == 0) begin
            expect_eq("first_beat_latency", 64'(cycle - e), 64'(4 + wait_sum - wbase));
        end
        repeat (LW) @(negedge clk);
        repeat (hold) @(negedge clk);
        expect_eq("burst_count", 64'(bursts - burst_base), 64'(exp_bursts));
        req_cc2mem = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int ab_acks;
        rst          = 1'b1;
        req_cc2mem   = 1'b0;
        adr_cc2mem   = 32'h0;
        wait_mode    = 0;
        err_beat     = -1;
        err_attempts = 0;
        burst_base   = 0;
        cur_base     = 32'h0;

        repeat (3) @(negedge clk);
        expect_eq("reset_bus_ctrl", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}), 64'(0));
        expect_eq("reset_bus_adr", 64'(wb_adr_o), 64'(0));
        expect_eq("reset_cache_side", 64'({ack_mem2cc, err_mem2cc, dat_mem2cc}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait slave
        refill(32'hFF07BD08, 32'hFF07BD00, -1, 0, 1, 1'b0, 0, 0, 2);
        // Random 1-10 wait cycles per beat
        refill(32'hA5552D0C, 32'hA5552D00, -1, 0, 1, 1'b0, 1, 0, 2);
        // Error on beat 2 of attempts 1 and 2, third attempt clean
        refill(32'h00001234, 32'h00001230, 2, 2, 3, 1'b0, 0, 0, 2);
        // Error on all three attempts: zero line with err on beat 0
        refill(32'hDEADBEE0, 32'hDEADBEE0, 2, 3, 3, 1'b1, 0, 0, 2);
        // Request held 3 cycles past delivery, then the earliest legal next request
        refill(32'h00000040, 32'h00000040, -1, 0, 1, 1'b0, 0, 3, 0);
        refill(32'h00000084, 32'h00000080, -1, 0, 1, 1'b0, 0, 0, 2);

        // Reset pulsed while beat 1 is on the bus
        wait_mode    = 0;
        err_beat     = -1;
        err_attempts = 0;
        cur_base     = 32'hCAFEF000;
        burst_base   = bursts;
        @(negedge clk);
        req_cc2mem = 1'b1;
        adr_cc2mem = 32'hCAFEF00C;
        repeat (2) @(negedge clk);
        expect_eq("beat1_adr_before_rst", 64'(wb_adr_o), 64'(32'hCAFEF004));
        rst = 1'b1;
        @(negedge clk);
        expect_eq("rst_midburst_bus", 64'({wb_cyc_o, wb_stb_o, wb_cti_o, wb_sel_o}), 64'(0));
        expect_eq("rst_midburst_adr", 64'(wb_adr_o), 64'(0));
        expect_eq("rst_midburst_cache", 64'({ack_mem2cc, err_mem2cc}), 64'(0));
        rst        = 1'b0;
        req_cc2mem = 1'b0;
        repeat (2) @(negedge clk);
        refill(32'hCAFEF00C, 32'hCAFEF000, -1, 0, 1, 1'b0, 0, 0, 2);

        // Request released during the burst: burst completes, no delivery
        wait_mode    = 0;
        err_beat     = -1;
        err_attempts = 0;
        cur_base     = 32'h55AA0010;
        burst_base   = bursts;
        ab_acks      = bus_acks;
        @(negedge clk);
        req_cc2mem = 1'b1;
        adr_cc2mem = 32'h55AA0018;
        repeat (2) @(negedge clk);
        req_cc2mem = 1'b0;
        repeat (10) @(negedge clk);
        expect_eq("abandon_bursts", 64'(bursts - burst_base), 64'(1));
        expect_eq("abandon_bus_acks", 64'(bus_acks - ab_acks), 64'(LW));
        expect_eq("abandon_cyc_low", 64'(wb_cyc_o), 64'(0));

        repeat (3) @(negedge clk);
        expect_eq("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
